// File: rtl/sic_lane_dispatcher_pkg.sv
// Shared types for the SIC lane dispatcher.
//   sic_info_t       : decoded control flags carried with an issued packet
//   sic_packet_t     : issued packet (valid strobe, flags, physical regs, tag)
//   sic_kind_t       : execution class of a packet (ALU / MEM / SIMPLE)
//   sic_fifo_entry_t : queued packet together with its precomputed class
//   sic_classify()   : packet -> class, shared with other SIC front ends
package sic_lane_dispatcher_pkg;

  // The packet layout fixes the physical register width for every user.
  localparam int SIC_NUM_PHY_REGS = 64;
  localparam int SIC_PR_W         = $clog2(SIC_NUM_PHY_REGS);

  typedef enum logic [1:0] {
    KIND_ALU    = 2'd0,
    KIND_MEM    = 2'd1,
    KIND_SIMPLE = 2'd2
  } sic_kind_t;

  typedef struct packed {
    logic read_rs;
    logic read_rt;
    logic write_gpr;
    logic mem_read;
    logic mem_write;
    logic use_alu;
    logic write_ecr;
  } sic_info_t;

  typedef struct packed {
    logic                valid;
    sic_info_t           info;
    logic [SIC_PR_W-1:0] phy_rs;
    logic [SIC_PR_W-1:0] phy_rt;
    logic [SIC_PR_W-1:0] phy_dst;
    logic [7:0]          rob_tag;
  } sic_packet_t;

  typedef struct packed {
    sic_packet_t pkt;
    sic_kind_t   kind;
  } sic_fifo_entry_t;

  // Memory access dominates; otherwise anything touching the ALU or the
  // ECR needs an ALU lane; everything else can go to a simple lane.
  function automatic sic_kind_t sic_classify(input sic_packet_t p);
    sic_kind_t k;
    if (p.info.mem_read || p.info.mem_write) begin
      k = KIND_MEM;
    end else if (p.info.use_alu || p.info.write_ecr) begin
      k = KIND_ALU;
    end else begin
      k = KIND_SIMPLE;
    end
    return k;
  endfunction

endpackage

// File: rtl/sic_pkt_fifo.sv
// In-order packet queue for the SIC lane dispatcher.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data at the tail (caller guarantees not full)
//   push_data  : packet plus its class
//   pop        : drop the head entry (caller guarantees not empty)
//   flush      : empty the queue; overrides push and pop
//   head       : entry at the head, meaningful only when empty = 0
//   count      : number of queued entries (0..DEPTH)
//   empty      : count == 0
module sic_pkt_fifo
  import sic_lane_dispatcher_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  sic_fifo_entry_t push_data,
  input  logic            pop,
  input  logic            flush,
  output sic_fifo_entry_t head,
  output logic [CW-1:0]   count,
  output logic            empty
);

  sic_fifo_entry_t mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush;
  assign head    = mem[rd_ptr];
  assign empty   = (count == '0);

  // Storage needs no reset: an entry is only observed after it was written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sic_lane_dispatcher.sv
// SIC lane dispatcher: queues issued packets in order, classifies them and
// hands the head packet to the lowest-index idle lane able to execute it.
// While a lane is busy, its packet's physical registers are advertised.
//   clk, rst_n    : clock, asynchronous active-low reset
//   req_instr     : queue has room this cycle
//   packet_in     : packet from the Issue Controller (valid = push request)
//   flush         : drop every queued, undispatched packet
//   lane_idle     : per-lane "waiting for an instruction"
//   lane_pkt      : per-lane dispatched packet, valid is a one-cycle strobe
//   adv_rs_addr   : per-lane advertised rs physical register (0 if none)
//   adv_rt_addr   : per-lane advertised rt physical register (0 if none)
//   adv_waddr     : per-lane advertised destination register (0 if none)
//   occupancy     : number of queued packets
//   overflow_err  : sticky, a valid packet arrived while req_instr was 0
//
// Handshakes: the issue side transfers a packet on a cycle where
// packet_in.valid && req_instr && !flush; a valid without req_instr is lost
// and flagged. The lane side has no back-pressure: a lane is offered a
// packet only while lane_idle is high, and lane_pkt.valid means it was taken.
//
// NUM_PHY_REGS must match SIC_NUM_PHY_REGS, which fixes the packet layout.
module sic_lane_dispatcher
  import sic_lane_dispatcher_pkg::*;
#(
  parameter int                     NUM_LANES    = 3,
  parameter int                     DEPTH        = 4,
  parameter int                     NUM_PHY_REGS = 64,
  parameter logic [NUM_LANES*3-1:0] LANE_CAPS    = 9'h111,
  localparam int PR_W = $clog2(NUM_PHY_REGS),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 req_instr,
  input  sic_packet_t          packet_in,
  input  logic                 flush,
  input  logic [NUM_LANES-1:0] lane_idle,
  output sic_packet_t          lane_pkt    [NUM_LANES],
  output logic [PR_W-1:0]      adv_rs_addr [NUM_LANES],
  output logic [PR_W-1:0]      adv_rt_addr [NUM_LANES],
  output logic [PR_W-1:0]      adv_waddr   [NUM_LANES],
  output logic [CW-1:0]        occupancy,
  output logic                 overflow_err
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  sic_fifo_entry_t        push_data;
  sic_fifo_entry_t        head;
  logic                   push;
  logic                   pop;
  logic                   empty;
  logic [CW-1:0]          count;
  logic [NUM_LANES-1:0]   guard;
  logic [NUM_LANES-1:0]   cap_hit;
  logic [NUM_LANES-1:0]   eligible;
  logic [NUM_LANES-1:0]   pick;
  logic [NUM_LANES-1:0]   dispatch;
  sic_packet_t            disp_pkt;

  assign req_instr = (count != DEPTH_C);
  assign occupancy = count;
  assign push      = packet_in.valid && req_instr && !flush;

  always_comb begin
    push_data.pkt  = packet_in;
    push_data.kind = sic_classify(packet_in);
  end

  sic_pkt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (count),
    .empty     (empty)
  );

  // guard masks a lane for the cycle after it was dispatched to, because
  // the lane only lowers lane_idle one cycle after taking the packet.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_elig
    assign cap_hit[g] = ((head.kind == KIND_ALU)    && LANE_CAPS[g*3])   ||
                        ((head.kind == KIND_MEM)    && LANE_CAPS[g*3+1]) ||
                        ((head.kind == KIND_SIMPLE) && LANE_CAPS[g*3+2]);
    assign eligible[g] = lane_idle[g] && !guard[g] && cap_hit[g];
  end

  // x & -x isolates the lowest set bit: the lowest-index eligible lane.
  assign pick     = eligible & (~eligible + NUM_LANES'(1));
  assign dispatch = (!empty && !flush) ? pick : '0;
  assign pop      = |dispatch;

  always_comb begin
    disp_pkt       = head.pkt;
    disp_pkt.valid = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guard        <= '0;
      overflow_err <= 1'b0;
    end else begin
      guard <= dispatch;
      if (packet_in.valid && !req_instr) begin
        overflow_err <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sic_packet_t hold_q;
    sic_packet_t adv_src;
    logic        active;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q <= '0;
      end else if (dispatch[g]) begin
        hold_q <= head.pkt;
      end
    end

    // In the dispatch cycle the lane has not latched anything yet, so the
    // head itself is advertised; afterwards the held copy takes over.
    assign adv_src = dispatch[g] ? head.pkt : hold_q;
    assign active  = dispatch[g] || guard[g] || !lane_idle[g];

    assign lane_pkt[g]    = dispatch[g] ? disp_pkt : '0;
    assign adv_rs_addr[g] = (active && adv_src.info.read_rs)   ? adv_src.phy_rs  : '0;
    assign adv_rt_addr[g] = (active && adv_src.info.read_rt)   ? adv_src.phy_rt  : '0;
    assign adv_waddr[g]   = (active && adv_src.info.write_gpr) ? adv_src.phy_dst : '0;
  end

endmodule

// File: tb/tb_sic_lane_dispatcher.sv
module tb_sic_lane_dispatcher;
  import sic_lane_dispatcher_pkg::*;

  localparam int NL    = 3;
  localparam int DEPTH = 4;
  localparam int PRW   = 6;
  localparam int CW    = 3;
  localparam int EXP_W = 16 + 4 + $bits(sic_packet_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sic_packet_t     packet_in;
  logic            flush;
  logic [NL-1:0]   lane_idle;

  logic            a_req, b_req, a_ovf, b_ovf;
  logic [CW-1:0]   a_occ, b_occ;
  sic_packet_t     a_pkt [NL];
  sic_packet_t     b_pkt [NL];
  logic [PRW-1:0]  a_rs [NL], a_rt [NL], a_wd [NL];
  logic [PRW-1:0]  b_rs [NL], b_rt [NL], b_wd [NL];

  sic_lane_dispatcher #(
    .NUM_LANES(NL), .DEPTH(DEPTH), .NUM_PHY_REGS(64), .LANE_CAPS(9'h111)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_instr(a_req), .packet_in(packet_in),
    .flush(flush), .lane_idle(lane_idle), .lane_pkt(a_pkt),
    .adv_rs_addr(a_rs), .adv_rt_addr(a_rt), .adv_waddr(a_wd),
    .occupancy(a_occ), .overflow_err(a_ovf)
  );

  sic_lane_dispatcher #(
    .NUM_LANES(NL), .DEPTH(DEPTH), .NUM_PHY_REGS(64), .LANE_CAPS(9'h007)
  ) dut_caps (
    .clk(clk), .rst_n(rst_n), .req_instr(b_req), .packet_in(packet_in),
    .flush(flush), .lane_idle(lane_idle), .lane_pkt(b_pkt),
    .adv_rs_addr(b_rs), .adv_rt_addr(b_rt), .adv_waddr(b_wd),
    .occupancy(b_occ), .overflow_err(b_ovf)
  );

  // Observed outputs of the instance under check.
  bit             sel;
  logic           m_req, m_ovf;
  logic [CW-1:0]  m_occ;
  sic_packet_t    m_pkt [NL];
  logic [PRW-1:0] m_rs [NL], m_rt [NL], m_wd [NL];

  always_comb begin
    m_req = sel ? b_req : a_req;
    m_ovf = sel ? b_ovf : a_ovf;
    m_occ = sel ? b_occ : a_occ;
    for (int l = 0; l < NL; l++) begin
      m_pkt[l] = sel ? b_pkt[l] : a_pkt[l];
      m_rs[l]  = sel ? b_rs[l]  : a_rs[l];
      m_rt[l]  = sel ? b_rt[l]  : a_rt[l];
      m_wd[l]  = sel ? b_wd[l]  : a_wd[l];
    end
  end

  // ---------------- reference model ----------------
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  int             next_tag = 100;
  bit             model_on = 0;
  logic [8:0]     m_caps = 9'h111;
  sic_packet_t    mq [$];
  sic_packet_t    r_hold [NL];
  bit             r_guard [NL];
  bit             r_ovf;
  int             e_occ;
  bit             e_req, e_ovf;
  logic [PRW-1:0] e_rs [NL], e_rt [NL], e_wd [NL];
  logic [EXP_W-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic int kind_of(input sic_packet_t p);
    if (p.info.mem_read || p.info.mem_write) return 1;
    if (p.info.use_alu || p.info.write_ecr) return 0;
    return 2;
  endfunction

  function automatic sic_packet_t mk_pkt(input int kind, input logic [7:0] tag,
      input logic [5:0] rs, input logic [5:0] rt, input logic [5:0] dst,
      input logic rrs, input logic rrt, input logic wg);
    sic_packet_t p;
    p = '0;
    p.rob_tag = tag; p.phy_rs = rs; p.phy_rt = rt; p.phy_dst = dst;
    p.info.read_rs = rrs; p.info.read_rt = rrt; p.info.write_gpr = wg;
    if (kind == 0) p.info.use_alu = 1'b1;
    if (kind == 1) p.info.mem_read = 1'b1;
    return p;
  endfunction

  function automatic sic_packet_t rand_pkt(input logic [7:0] tag);
    sic_packet_t p;
    int k;
    p = '0;
    p.info = 7'($urandom);
    k = $urandom_range(0, 2);
    if (k != 1) begin p.info.mem_read = 1'b0; p.info.mem_write = 1'b0; end
    if (k == 2) begin p.info.use_alu = 1'b0; p.info.write_ecr = 1'b0; end
    p.phy_rs = 6'($urandom); p.phy_rt = 6'($urandom); p.phy_dst = 6'($urandom);
    p.rob_tag = tag;
    return p;
  endfunction

  // One cycle of the specification's behaviour, evaluated on this cycle's
  // inputs and the model state left by the previous clock edge.
  task automatic model_step();
    int d;
    sic_packet_t src, p;
    bit act;
    e_occ = mq.size();
    e_req = (mq.size() < DEPTH);
    e_ovf = r_ovf;
    d = -1;
    if (mq.size() > 0 && !flush) begin
      for (int l = 0; l < NL; l++)
        if (d < 0 && lane_idle[l] && !r_guard[l] && m_caps[l*3 + kind_of(mq[0])]) d = l;
    end
    for (int l = 0; l < NL; l++) begin
      src = (d == l) ? mq[0] : r_hold[l];
      act = (d == l) || r_guard[l] || !lane_idle[l];
      e_rs[l] = (act && src.info.read_rs)   ? src.phy_rs  : '0;
      e_rt[l] = (act && src.info.read_rt)   ? src.phy_rt  : '0;
      e_wd[l] = (act && src.info.write_gpr) ? src.phy_dst : '0;
    end
    if (d >= 0) begin
      p = mq[0];
      p.valid = 1'b1;
      exp_q.push_back({16'(cyc), 4'(d), p});
    end
    for (int l = 0; l < NL; l++) r_guard[l] = (d == l);
    if (d >= 0) r_hold[d] = mq.pop_front();
    if (packet_in.valid && !e_req) r_ovf = 1'b1;
    if (flush) mq.delete();
    else if (packet_in.valid && e_req) mq.push_back(packet_in);
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit v, input sic_packet_t p, input bit f, input logic [NL-1:0] idle);
    @(posedge clk);
    #1;
    packet_in = p;
    packet_in.valid = v;
    flush = f;
    lane_idle = idle;
    cyc++;
    model_step();
    model_on = 1;
  endtask

  task automatic idle_steps(input int n, input logic [NL-1:0] idle);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, idle);
  endtask

  task automatic rand_steps(input int n);
    logic [NL-1:0] idle;
    for (int i = 0; i < n; i++) begin
      for (int l = 0; l < NL; l++) idle[l] = ($urandom_range(0, 9) < 7);
      step(1'($urandom_range(0, 1)), rand_pkt(8'(next_tag)), ($urandom_range(0, 99) < 3), idle);
      next_tag++;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_occ"}, m_occ, 0);
    for (int l = 0; l < NL; l++) begin
      check($sformatf("%s_adv_rs%0d", tag, l), m_rs[l], 0);
      check($sformatf("%s_adv_rt%0d", tag, l), m_rt[l], 0);
      check($sformatf("%s_adv_wd%0d", tag, l), m_wd[l], 0);
      check($sformatf("%s_valid%0d", tag, l), m_pkt[l].valid, 0);
    end
  endtask

  task automatic do_reset(input bit mid);
    if (mid) begin
      @(negedge clk);
      #2;
    end
    model_on = 0;
    packet_in = '0;
    flush = 1'b0;
    rst_n = 1'b0;
    #1;
    if (mid) check_cleared("rst_mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    exp_q.delete();
    r_ovf = 1'b0;
    for (int l = 0; l < NL; l++) begin r_hold[l] = '0; r_guard[l] = 1'b0; end
    #1;
    check_cleared("post_rst");
    check("post_rst_req", m_req, 1);
    check("post_rst_ovf", m_ovf, 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [NL-1:0] prev_v;

  always @(negedge clk) begin
    int nv;
    int vl;
    logic [EXP_W-1:0] e;
    if (model_on && rst_n) begin
      nv = 0;
      vl = 0;
      check("occupancy", m_occ, e_occ);
      check("req_instr", m_req, e_req);
      check("overflow_err", m_ovf, e_ovf);
      for (int l = 0; l < NL; l++) begin
        check($sformatf("adv_rs%0d", l), m_rs[l], e_rs[l]);
        check($sformatf("adv_rt%0d", l), m_rt[l], e_rt[l]);
        check($sformatf("adv_wd%0d", l), m_wd[l], e_wd[l]);
        if (m_pkt[l].valid) begin
          nv++;
          vl = l;
          check($sformatf("guard_gap%0d", l), prev_v[l], 0);
        end
        prev_v[l] = m_pkt[l].valid;
      end
      if (nv > 0) begin
        check("dispatch_count", nv, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_dispatch", {16'(cyc), 4'(vl), m_pkt[vl]}, 0);
        end else begin
          e = exp_q.pop_front();
          check("dispatch", {16'(cyc), 4'(vl), m_pkt[vl]}, e);
        end
      end else if (exp_q.size() > 0 && exp_q[0][EXP_W-1 -: 16] <= 16'(cyc)) begin
        e = exp_q.pop_front();
        check("missing_dispatch", 0, e);
      end
    end else begin
      prev_v = '0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    packet_in = '0;
    flush = 1'b0;
    lane_idle = '1;
    sel = 0;
    do_reset(0);

    // ALU packet to lane 0, advertisement held while busy, released after.
    step(1'b1, mk_pkt(0, 8'd1, 6'd5, 6'd0, 6'd9, 1'b1, 1'b0, 1'b1), 1'b0, 3'b111);
    step(1'b0, '0, 1'b0, 3'b111);
    sample();
    check("t1_valid0", m_pkt[0].valid, 1);
    check("t1_adv_rs0", m_rs[0], 5);
    check("t1_adv_wd0", m_wd[0], 9);
    idle_steps(4, 3'b110);
    sample();
    check("t1_hold_rs0", m_rs[0], 5);
    check("t1_hold_wd0", m_wd[0], 9);
    step(1'b0, '0, 1'b0, 3'b111);
    sample();
    check("t1_release_rs0", m_rs[0], 0);
    check("t1_release_wd0", m_wd[0], 0);

    // MEM blocks the head while lane 1 is busy; the ALU behind it waits.
    step(1'b1, mk_pkt(1, 8'd2, 6'd3, 6'd4, 6'd0, 1'b1, 1'b1, 1'b0), 1'b0, 3'b101);
    step(1'b1, mk_pkt(0, 8'd3, 6'd6, 6'd7, 6'd8, 1'b1, 1'b1, 1'b1), 1'b0, 3'b101);
    step(1'b0, '0, 1'b0, 3'b101);
    sample();
    check("t2_blocked_occ", m_occ, 2);
    check("t2_no_alu", m_pkt[0].valid, 0);
    idle_steps(3, 3'b111);

    // Fill with all lanes busy, then overflow.
    for (int i = 0; i < 4; i++) step(1'b1, rand_pkt(8'(10 + i)), 1'b0, 3'b000);
    step(1'b1, rand_pkt(8'd14), 1'b0, 3'b000);
    sample();
    check("t3_full_occ", m_occ, 4);
    check("t3_full_req", m_req, 0);
    step(1'b0, '0, 1'b0, 3'b000);
    sample();
    check("t3_ovf", m_ovf, 1);
    check("t3_occ_kept", m_occ, 4);
    idle_steps(12, 3'b111);

    // Flush with a simultaneous push.
    for (int i = 0; i < 3; i++) step(1'b1, rand_pkt(8'(20 + i)), 1'b0, 3'b000);
    step(1'b1, rand_pkt(8'd23), 1'b1, 3'b111);
    step(1'b0, '0, 1'b0, 3'b111);
    sample();
    check("t4_flush_occ", m_occ, 0);
    idle_steps(3, 3'b111);

    rand_steps(400);
    idle_steps(16, 3'b111);

    // Reset with two queued packets and lane 0 busy.
    step(1'b1, mk_pkt(0, 8'd30, 6'd7, 6'd0, 6'd11, 1'b1, 1'b0, 1'b1), 1'b0, 3'b111);
    step(1'b0, '0, 1'b0, 3'b111);
    step(1'b1, mk_pkt(1, 8'd31, 6'd1, 6'd2, 6'd3, 1'b1, 1'b1, 1'b1), 1'b0, 3'b100);
    step(1'b1, mk_pkt(1, 8'd32, 6'd4, 6'd5, 6'd6, 1'b1, 1'b1, 1'b1), 1'b0, 3'b100);
    step(1'b0, '0, 1'b0, 3'b100);
    sample();
    check("t6_pre_occ", m_occ, 2);
    check("t6_pre_rs0", m_rs[0], 7);
    do_reset(1);

    // Lane 0 accepts every class; three SIMPLE packets in a row.
    sel = 1;
    m_caps = 9'h007;
    lane_idle = '1;
    do_reset(0);
    for (int i = 0; i < 3; i++) step(1'b1, mk_pkt(2, 8'(40 + i), 6'd1, 6'd2, 6'd3, 1'b0, 1'b0, 1'b1), 1'b0, 3'b111);
    sample();
    check("t5_gap_lane0", m_pkt[0].valid, 0);
    idle_steps(6, 3'b111);
    rand_steps(150);
    idle_steps(20, 3'b111);
    sample();
    check("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sic_lane_dispatcher.md
Name: sic_lane_dispatcher

Overview:
- Next-generation front end for the SIC execution path. It sits between the Issue Controller and NUM_LANES sub-executor lanes (sic_exec_alu/mem/simple style).
- Buffers up to DEPTH issued packets in order and classifies each one as ALU, MEM or SIMPLE.
- Dispatches the head packet to the lowest-index idle lane whose capability mask covers its kind.
- Holds a per-lane PR advertisement (rs/rt/dst) for as long as that lane is busy. This replaces the single-instruction, fixed three-way selection with N capability-configured lanes, a queue and a flush.

Parameters:
- NUM_LANES, 3, number of execution lanes (1..8).
- DEPTH, 4, packet FIFO depth; power of two, at least 2.
- NUM_PHY_REGS, 64, physical register count; PR_W = $clog2(NUM_PHY_REGS).
- LANE_CAPS, 9'h111, NUM_LANES*3 bits; bit lane*3+k set means the lane accepts kind k (k: 0=ALU, 1=MEM, 2=SIMPLE). The default gives lane0=ALU, lane1=MEM, lane2=SIMPLE.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low (decided).
- req_instr  out  1  FIFO can accept a packet this cycle.
- packet_in  in  sic_packet_t  packet from the Issue Controller; valid marks a push.
- flush  in  1  discard all queued, undispatched packets.
- lane_idle  in  NUM_LANES  per-lane req_instr from the lanes (1 = waiting for an instruction).
- lane_pkt  out  sic_packet_t[NUM_LANES]  dispatched packet; valid is a 1-cycle strobe.
- adv_rs_addr  out  PR_W x NUM_LANES  PR advertisement for rs, per lane.
- adv_rt_addr  out  PR_W x NUM_LANES  PR advertisement for rt, per lane.
- adv_waddr  out  PR_W x NUM_LANES  PR advertisement for the destination, per lane.
- occupancy  out  $clog2(DEPTH)+1  number of queued packets.
- overflow_err  out  1  sticky: a valid packet arrived while req_instr=0.

Behaviour:
- Reset:
  - FIFO pointers, occupancy and all hold registers are 0.
  - Guard bits and overflow_err are 0.
  - lane_pkt valid and all adv_* are 0.
  - req_instr is 1 whenever rst_n=1 after reset.
- Classification:
  - MEM if info.mem_read or info.mem_write.
  - Else ALU if info.use_alu or info.write_ecr.
  - Else SIMPLE.
  - The kind is computed at push time and stored alongside the packet.
- Flow control:
  - req_instr = (occupancy < DEPTH); it is combinational from registered state only.
  - A push happens when packet_in.valid && req_instr && !flush.
  - packet_in.valid while req_instr=0 drops the packet and sets overflow_err (cleared only by reset).
- Dispatch (combinational choice, registered effect):
  - Lane l is eligible when lane_idle[l] && !guard[l] && LANE_CAPS[l*3+kind(head)].
  - When the FIFO is non-empty and flush=0, the head goes to the lowest-index eligible lane. lane_pkt[l] = head with valid=1, and the FIFO pops.
  - At most one dispatch per cycle. Strict in-order: a head with no eligible lane blocks everything behind it.
  - A lane whose capability bits are all 0 is never selected.
- Latency: a packet pushed in cycle t is dispatched at the earliest in cycle t+1. There is no bypass.
- Guard:
  - guard[l] is set in the cycle after dispatch to l and clears one cycle later.
  - It covers lane_idle dropping one cycle late and prevents a double dispatch.
- Push and pop in the same cycle leave occupancy unchanged. Pointers wrap modulo DEPTH.
- Advertisement per lane:
  - hold[l] is loaded with the packet on dispatch.
  - adv_src = (dispatching to l) ? head : hold[l].
  - active = dispatching to l || guard[l] || !lane_idle[l].
  - adv_rs_addr[l] = (active && adv_src.info.read_rs) ? adv_src.phy_rs : 0. adv_rt_addr and adv_waddr follow the same rule using read_rt/phy_rt and write_gpr/phy_dst.
- Flush:
  - Same cycle: no dispatch and no push (flush wins). Next cycle: occupancy=0 and pointers=0.
  - Lanes already dispatched are unaffected and keep advertising.
- Reset mid-operation: everything clears asynchronously, and queued packets are lost.

Decomposition:
- Shared package (structs.svh): a sic_kind_t enum {KIND_ALU, KIND_MEM, KIND_SIMPLE} and a sic_classify function returning sic_kind_t from sic_packet_t. Move sic_packet_t's existing classification there so single_instruction_controller can reuse it.
- Sub-module: sic_pkt_fifo (parametrised DEPTH, payload = sic_packet_t + sic_kind_t, push/pop/flush, count). Arbitration and advertisement logic stay in the top level.

Test Plan:
- Reset, then push ALU (phy_rs=5, phy_dst=9, read_rs=1, write_gpr=1) with all lanes idle:
  - cycle +1: lane_pkt[0].valid=1, adv_rs_addr[0]=5, adv_waddr[0]=9.
  - Hold lane_idle[0]=0 for 4 cycles: adv stays 5/9.
  - After lane_idle[0] returns to 1 (guard clear): adv goes to 0.
- Push MEM then ALU with lane1 busy:
  - MEM blocks at the head and the ALU is not dispatched to lane0 (in-order).
  - Release lane1: MEM dispatches, and the ALU follows one cycle later.
- Push 4 packets with all lanes busy: occupancy=4 and req_instr=0. A 5th valid sets overflow_err=1 and occupancy stays 4.
- LANE_CAPS=9'h007 (lane0 takes everything), 3 SIMPLE packets: dispatched only to lane0, never twice within the guard window.
- Occupancy 3 plus flush with a simultaneous valid push: next cycle occupancy=0, no lane_pkt valid, and the pushed packet is discarded.
- Reset asserted while occupancy=2 and lane0 busy: all adv_* are 0 immediately, occupancy=0, and req_instr=1 once rst_n=1.
